scarv_cop_insn_if: RTL and testbench

Parametrised CPU/COP instruction interface for the SCARV crypto co-processor. It accepts instructions on the CPU request/acknowledge handshake and buffers them in an in-order queue of configurable depth. It dispatches them one at a time to the COP execute stage over a valid/ready handshake and returns each result on the response/acknowledge handshake. It also supports abort-driven flushing and clock-request generation.

---
 rtl/scarv_cop_insn_if.sv | 114 +++++++++++
 tb/tb_scarv_cop_insn_if.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_insn_if.sv
// scarv_cop_insn_if: CPU/COP instruction interface. Queues accepted instructions,
// dispatches them one at a time to the execute stage, and returns results.
//   g_clk, g_resetn        clock, synchronous active-low reset
//   g_clk_req              clock request while any work is pending
//   cpu_insn_req/enc/rs1   instruction request; cop_insn_ack is a one-cycle accept pulse
//   cpu_abort_req          flushes the queue and drops an in-flight result
//   cop_insn_rsp + cop_*   response, held until cpu_insn_ack
//   ex_valid/ready/enc/rs1 dispatch handshake to the execute stage
//   ex_done + ex_*         completion strobe and payload from the execute stage
//   cop_count              occupied queue entries
module scarv_cop_insn_if #(
   parameter int DEPTH = 4,
   parameter int ENC_W = 32,
   parameter int XLEN  = 32
) (
   input  logic                     g_clk,
   input  logic                     g_resetn,
   output logic                     g_clk_req,
   input  logic                     cpu_insn_req,
   output logic                     cop_insn_ack,
   input  logic                     cpu_abort_req,
   input  logic [ENC_W-1:0]         cpu_insn_enc,
   input  logic [XLEN-1:0]          cpu_rs1,
   output logic                     cop_wen,
   output logic [4:0]               cop_waddr,
   output logic [XLEN-1:0]          cop_wdata,
   output logic [2:0]               cop_result,
   output logic                     cop_insn_rsp,
   input  logic                     cpu_insn_ack,
   output logic                     ex_valid,
   input  logic                     ex_ready,
   output logic [ENC_W-1:0]         ex_enc,
   output logic [XLEN-1:0]          ex_rs1,
   input  logic                     ex_done,
   input  logic                     ex_wen,
   input  logic [4:0]               ex_waddr,
   input  logic [XLEN-1:0]          ex_wdata,
   input  logic [2:0]               ex_result,
   output logic [$clog2(DEPTH):0]   cop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [ENC_W-1:0] enc_q [DEPTH];
   logic [XLEN-1:0]  rs1_q [DEPTH];
   logic [AW-1:0]    head, tail;
   logic [CW-1:0]    count;
   logic             issued, drop_q, rsp_valid, ack_q;
   logic             full, empty, push, pop, done;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   // ack_q blocks a second capture of the request still held during the ack cycle
   assign push  = cpu_insn_req & ~full & ~ack_q & ~cpu_abort_req;
   // valid is withheld during an abort so the execute stage never takes a flushed entry
   assign ex_valid = ~empty & ~issued & ~rsp_valid & ~cpu_abort_req;
   assign pop   = ex_valid & ex_ready;
   assign done  = ex_done & issued;
   assign ex_enc = ex_valid ? enc_q[head] : '0;
   assign ex_rs1 = ex_valid ? rs1_q[head] : '0;
   assign cop_insn_ack = ack_q;
   assign cop_insn_rsp = rsp_valid;
   assign cop_count    = count;
   assign g_clk_req    = cpu_insn_req | ~empty | issued | rsp_valid;
   always_ff @(posedge g_clk) begin
      if (push) begin
         enc_q[tail] <= cpu_insn_enc;
         rs1_q[tail] <= cpu_rs1;
      end
   end
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         issued     <= 1'b0;
         drop_q     <= 1'b0;
         rsp_valid  <= 1'b0;
         ack_q      <= 1'b0;
         cop_wen    <= 1'b0;
         cop_waddr  <= '0;
         cop_wdata  <= '0;
         cop_result <= '0;
      end else begin
         ack_q <= push;
         if (cpu_abort_req) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
         // pop needs !issued and done needs issued, so they never coincide
         if (done) begin
            issued <= 1'b0;
            drop_q <= 1'b0;
         end else if (pop) begin
            issued <= 1'b1;
         end else if (cpu_abort_req && issued) begin
            drop_q <= 1'b1;
         end
         // a result arriving while aborted, or after an abort, is discarded
         if (done && !drop_q && !cpu_abort_req) begin
            rsp_valid  <= 1'b1;
            cop_wen    <= ex_wen;
            cop_waddr  <= ex_waddr;
            cop_wdata  <= ex_wdata;
            cop_result <= ex_result;
         end else if (cpu_insn_ack) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_scarv_cop_insn_if.sv
// tb_scarv_cop_insn_if: self-checking bench for scarv_cop_insn_if against a queue-based reference model.
module tb_scarv_cop_insn_if;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;
   logic g_clk = 1'b0;
   logic g_resetn, g_clk_req, cpu_insn_req, cop_insn_ack, cpu_abort_req;
   logic [31:0] cpu_insn_enc, cpu_rs1, cop_wdata, ex_enc, ex_rs1, ex_wdata;
   logic cop_wen, cop_insn_rsp, cpu_insn_ack, ex_valid, ex_ready, ex_done, ex_wen;
   logic [4:0] cop_waddr, ex_waddr;
   logic [2:0] cop_result, ex_result;
   logic [CW-1:0] cop_count;
   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] mq[$];
   bit m_issued, m_drop, m_rsp, m_ack;
   logic m_wen;
   logic [4:0] m_waddr;
   logic [31:0] m_wdata;
   logic [2:0] m_result;

   always #5 g_clk = ~g_clk;

   scarv_cop_insn_if #(.DEPTH(DEPTH), .ENC_W(32), .XLEN(32)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
      .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack), .cpu_abort_req(cpu_abort_req),
      .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
      .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata), .cop_result(cop_result),
      .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_enc(ex_enc), .ex_rs1(ex_rs1),
      .ex_done(ex_done), .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .ex_result(ex_result), .cop_count(cop_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_clk_req"}, g_clk_req, 0);
      chk({tag, "_ack"}, cop_insn_ack, 0);
      chk({tag, "_rsp"}, cop_insn_rsp, 0);
      chk({tag, "_wen"}, cop_wen, 0);
      chk({tag, "_waddr"}, cop_waddr, 0);
      chk({tag, "_wdata"}, cop_wdata, 0);
      chk({tag, "_result"}, cop_result, 0);
      chk({tag, "_ex_valid"}, ex_valid, 0);
      chk({tag, "_ex_enc"}, ex_enc, 0);
      chk({tag, "_ex_rs1"}, ex_rs1, 0);
      chk({tag, "_count"}, cop_count, 0);
   endtask

   // Compare every observable output with the model state for the current cycle.
   task automatic check_outputs();
      logic [63:0] h;
      bit exv;
      exv = mq.size() != 0 && !m_issued && !m_rsp;
      chk("ack", cop_insn_ack, m_ack);
      if (!cpu_abort_req) begin
         chk("ex_valid", ex_valid, exv);
         if (exv) begin
            h = mq[0];
            chk("ex_enc", ex_enc, h[63:32]);
            chk("ex_rs1", ex_rs1, h[31:0]);
         end
      end
      chk("count", cop_count, mq.size());
      chk("rsp", cop_insn_rsp, m_rsp);
      if (m_rsp) begin
         chk("wen", cop_wen, m_wen);
         chk("waddr", cop_waddr, m_waddr);
         chk("wdata", cop_wdata, m_wdata);
         chk("result", cop_result, m_result);
      end
      chk("clk_req", g_clk_req, cpu_insn_req || mq.size() != 0 || m_issued || m_rsp);
   endtask

   // Advance the model by one clock using the inputs held across the edge.
   task automatic model_update();
      bit push, pop, done;
      if (!g_resetn) begin
         mq.delete();
         m_issued = 0; m_drop = 0; m_rsp = 0; m_ack = 0;
         return;
      end
      push = cpu_insn_req && mq.size() < DEPTH && !m_ack && !cpu_abort_req;
      pop  = mq.size() != 0 && !m_issued && !m_rsp && !cpu_abort_req && ex_ready;
      done = ex_done && m_issued;
      m_ack = push;
      if (m_rsp && cpu_insn_ack) m_rsp = 0;
      if (done) begin
         if (!m_drop && !cpu_abort_req) begin
            m_rsp = 1; m_wen = ex_wen; m_waddr = ex_waddr; m_wdata = ex_wdata; m_result = ex_result;
         end
         m_issued = 0;
         m_drop = 0;
      end else if (cpu_abort_req && m_issued) begin
         m_drop = 1;
      end
      if (pop) begin
         void'(mq.pop_front());
         m_issued = 1;
      end
      if (cpu_abort_req) mq.delete();
      if (push) mq.push_back({cpu_insn_enc, cpu_rs1});
   endtask

   task automatic cyc();
      #1;
      check_outputs();
      @(posedge g_clk);
      model_update();
      #1;
   endtask

   task automatic rand_payload();
      ex_wen = 1'($urandom);
      ex_waddr = 5'($urandom);
      ex_wdata = $urandom;
      ex_result = 3'($urandom);
   endtask

   task automatic send(input logic [31:0] e, input logic [31:0] r);
      cpu_insn_enc = e;
      cpu_rs1 = r;
      cpu_insn_req = 1;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (m_ack) break;
      end
      chk("send_ack", cop_insn_ack, 1);
      cpu_insn_req = 0;
   endtask

   // Run everything pending to completion; each response is held ack_delay cycles before ack.
   task automatic drain(input int ack_delay);
      int held;
      held = 0;
      cpu_insn_req = 0;
      cpu_abort_req = 0;
      ex_ready = 1;
      for (int i = 0; i < 400 && (mq.size() != 0 || m_issued || m_rsp || m_ack); i++) begin
         ex_done = m_issued;
         rand_payload();
         cpu_insn_ack = m_rsp && held >= ack_delay;
         cyc();
         held = m_rsp ? held + 1 : 0;
      end
      ex_done = 0;
      cpu_insn_ack = 0;
      ex_ready = 0;
      cyc();
      chk("drain_count", cop_count, 0);
      chk("drain_rsp", cop_insn_rsp, 0);
   endtask

   initial begin
      g_resetn = 0;
      cpu_insn_req = 0; cpu_abort_req = 0; cpu_insn_enc = 0; cpu_rs1 = 0; cpu_insn_ack = 0;
      ex_ready = 0; ex_done = 0; ex_wen = 0; ex_waddr = 0; ex_wdata = 0; ex_result = 0;
      repeat (2) @(posedge g_clk);
      #1;
      g_resetn = 1;
      check_zero("reset");

      // single instruction
      cpu_insn_req = 1; cpu_insn_enc = 32'h0000_100B; cpu_rs1 = 32'hDEAD_BEEF; ex_ready = 1;
      cyc();
      chk("single_ack", cop_insn_ack, 1);
      chk("single_ex_valid", ex_valid, 1);
      chk("single_ex_enc", ex_enc, 32'h0000_100B);
      chk("single_ex_rs1", ex_rs1, 32'hDEAD_BEEF);
      cyc();
      cpu_insn_req = 0;
      ex_done = 1; ex_wen = 1; ex_waddr = 5; ex_wdata = 32'h1234; ex_result = 0;
      cyc();
      ex_done = 0;
      for (int i = 0; i < 3; i++) begin
         chk("single_rsp", cop_insn_rsp, 1);
         chk("single_wdata", cop_wdata, 32'h1234);
         chk("single_waddr", cop_waddr, 5);
         cyc();
      end
      cpu_insn_ack = 1;
      cyc();
      cpu_insn_ack = 0;
      chk("single_rsp_drop", cop_insn_rsp, 0);

      // fill the queue, stall the extra request
      ex_ready = 0;
      for (int i = 0; i < DEPTH; i++) send($urandom, $urandom);
      cyc();
      chk("fill_count", cop_count, DEPTH);
      cpu_insn_req = 1; cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("stall_ack", cop_insn_ack, 0);
         chk("stall_count", cop_count, DEPTH);
      end
      ex_ready = 1;
      cyc();
      ex_ready = 0;
      chk("freed_ack", cop_insn_ack, 0);
      chk("freed_count", cop_count, DEPTH - 1);
      cyc();
      chk("late_ack", cop_insn_ack, 1);
      chk("late_count", cop_count, DEPTH);
      cpu_insn_req = 0;
      drain(0);

      // ordering with slow response acknowledge
      for (int i = 0; i < 3; i++) send($urandom, $urandom);
      drain(5);

      // abort while one is issued and two are queued
      ex_ready = 1;
      send($urandom, $urandom);
      cyc();
      ex_ready = 0;
      send($urandom, $urandom);
      send($urandom, $urandom);
      cyc();
      chk("pre_abort_count", cop_count, 2);
      cpu_abort_req = 1;
      cyc();
      cpu_abort_req = 0;
      chk("abort_count", cop_count, 0);
      ex_done = 1; rand_payload();
      cyc();
      ex_done = 0;
      chk("abort_drop_rsp", cop_insn_rsp, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("abort_ex_valid", ex_valid, 0);
         chk("abort_rsp", cop_insn_rsp, 0);
      end
      ex_ready = 1;
      send($urandom, $urandom);
      drain(1);

      // abort coincident with a request and with ex_done
      ex_ready = 1;
      send($urandom, $urandom);
      cyc();
      ex_ready = 0;
      cpu_insn_req = 1; cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
      ex_done = 1; rand_payload(); cpu_abort_req = 1;
      cyc();
      cpu_abort_req = 0; ex_done = 0;
      chk("coinc_ack", cop_insn_ack, 0);
      chk("coinc_rsp", cop_insn_rsp, 0);
      for (int i = 0; i < 10 && !m_ack; i++) cyc();
      chk("coinc_late_ack", cop_insn_ack, 1);
      cpu_insn_req = 0;
      drain(0);

      // reset with a response pending
      ex_ready = 1;
      send($urandom, $urandom);
      cyc();
      ex_done = 1; rand_payload();
      cyc();
      ex_done = 0;
      chk("prerst_rsp", cop_insn_rsp, 1);
      g_resetn = 0;
      cyc();
      g_resetn = 1;
      check_zero("midrst");
      ex_done = 1; rand_payload();
      cyc();
      ex_done = 0;
      chk("spurious_done_rsp", cop_insn_rsp, 0);
      chk("spurious_done_valid", ex_valid, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (m_ack) cpu_insn_req = 0;
         if (!cpu_insn_req && $urandom_range(0, 2) == 0) begin
            cpu_insn_req = 1; cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
         end
         ex_ready = 1'($urandom);
         ex_done = m_issued ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         rand_payload();
         cpu_insn_ack = m_rsp ? 1'($urandom) : ($urandom_range(0, 7) == 0);
         cpu_abort_req = $urandom_range(0, 24) == 0;
         cyc();
      end
      drain(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
